// File: rtl/paper_pkg.sv
// Shared definitions for the PaperProcessor branch path:
// opcodes, sequencer states and jump-check vectors.
package paper_pkg;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JNO  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] CHECK_TAKEN     = 2'b10;
  localparam logic [1:0] CHECK_NOT_TAKEN = 2'b01;
  localparam logic [1:0] CHECK_FORCE     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FLAG,
    S_RESOLVE,
    S_SETTLE,
    S_HALT
  } seq_state_t;

endpackage

// File: rtl/flag_timer.sv
// Saturating wait counter; expired is high once the
// count has reached FLAG_TIMEOUT-1.
module flag_timer #(
  parameter int FLAG_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(FLAG_TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jno_branch_sequencer.sv
// Branch sequencer: owns the PC, resolves JNO/JMP and
// drives the jump-check vector and override.
module jno_branch_sequencer
  import paper_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int FLAG_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      instr_op,
  input  logic [PC_W-1:0] target,
  input  logic            flag_valid,
  input  logic            flag_nz,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      check,
  output logic            enabling,
  output logic            pc_load,
  output logic            busy,
  output logic            halted,
  output logic            timeout
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [1:0]      check_q, check_d;
  logic            enabling_q, enabling_d;
  logic            pc_load_q, pc_load_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic            timeout_q, timeout_d;
  logic            accept;
  logic            expired;
  logic            in_wait;

  assign in_wait     = (state_q == S_WAIT_FLAG);
  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;

  // Counts only flag-less wait cycles; held at zero elsewhere
  flag_timer #(
    .FLAG_TIMEOUT(FLAG_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_wait),
    .en     (in_wait && !flag_valid),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    check_d    = check_q;
    enabling_d = 1'b0;
    pc_load_d  = 1'b0;
    busy_d     = busy_q;
    halted_d   = halted_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (instr_op == OP_SEQ): begin
              pc_d = pc_q + PC_W'(1);
            end
            (instr_op == OP_JMP): begin
              pc_d       = target;
              enabling_d = 1'b1;
              check_d    = CHECK_FORCE;
              pc_load_d  = 1'b1;
              busy_d     = 1'b1;
              state_d    = S_SETTLE;
            end
            (instr_op == OP_JNO): begin
              tgt_d   = target;
              busy_d  = 1'b1;
              state_d = S_WAIT_FLAG;
            end
            (instr_op == OP_HALT): begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_FLAG: begin
        // A flag on the expiry cycle takes priority
        if (flag_valid) begin
          check_d = flag_nz ? CHECK_TAKEN : CHECK_NOT_TAKEN;
          state_d = S_RESOLVE;
        end else if (expired) begin
          check_d   = CHECK_NOT_TAKEN;
          timeout_d = 1'b1;
          state_d   = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (check_q[1]) begin
          pc_d      = tgt_q;
          pc_load_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
        check_d = 2'b00;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        check_d = 2'b00;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_HALT: begin
        busy_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      tgt_q      <= '0;
      check_q    <= 2'b00;
      enabling_q <= 1'b0;
      pc_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      check_q    <= check_d;
      enabling_q <= enabling_d;
      pc_load_q  <= pc_load_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pc       = pc_q;
  assign check    = check_q;
  assign enabling = enabling_q;
  assign pc_load  = pc_load_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign timeout  = timeout_q;

endmodule
